// File: rtl/arm_run_sequencer_if.sv
// arm_run_sequencer_if: control and status bundle between the run sequencer and its user
interface arm_run_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 4
);
    logic             start;
    logic             halt_req;
    logic             core_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic [RUN_W-1:0] run_idx;
    logic [CNT_W-1:0] cycle_cnt;
    modport master (
        output start, halt_req,
        input  core_rst, running, done, timeout, run_idx, cycle_cnt
    );
    modport slave (
        input  start, halt_req,
        output core_rst, running, done, timeout, run_idx, cycle_cnt
    );
endinterface

// File: rtl/arm_run_sequencer.sv
// arm_run_sequencer: drives core reset and sequences NUM_RUNS reset/run passes with halt and timeout
module arm_run_sequencer #(
    parameter int RST_CYCLES          = 2,
    parameter int RUN_CYCLES          = 300,
    parameter int NUM_RUNS            = 2,
    parameter int CNT_W               = 16,
    parameter int RUN_W               = 4,
    parameter bit CORE_RST_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    arm_run_sequencer_if.slave   sif
);
    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUNS_LAST = RUN_W'(NUM_RUNS - 1);
    if (RST_CYCLES < 1 || RST_CYCLES > (1 << CNT_W)) begin : g_bad_rst
        $fatal(1, "RST_CYCLES out of range");
    end
    if (RUN_CYCLES < 1 || RUN_CYCLES > (1 << CNT_W)) begin : g_bad_run
        $fatal(1, "RUN_CYCLES out of range");
    end
    if (NUM_RUNS < 1 || NUM_RUNS > (1 << RUN_W)) begin : g_bad_num
        $fatal(1, "NUM_RUNS out of range");
    end
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [RUN_W-1:0] run_idx_q, run_idx_d;
    logic             timeout_q, timeout_d;
    logic             run_end;
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        run_idx_d   = run_idx_q;
        timeout_d   = timeout_q;
        run_end     = sif.halt_req || cycle_cnt_q == RUN_LAST;
        unique case (state_q)
            IDLE, DONE: begin
                if (sif.start) begin
                    state_d     = RESET;
                    cycle_cnt_d = '0;
                    run_idx_d   = '0;
                    timeout_d   = 1'b0;
                end
            end
            RESET: begin
                state_d     = cycle_cnt_q == RST_LAST ? RUN : RESET;
                cycle_cnt_d = cycle_cnt_q == RST_LAST ? '0 : cycle_cnt_q + 1'b1;
            end
            RUN: begin
                if (run_end) begin
                    // halt_req beats budget expiry, so a halt on the last cycle is not a timeout
                    timeout_d = timeout_q | ~sif.halt_req;
                    if (run_idx_q == RUNS_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d     = RESET;
                        run_idx_d   = run_idx_q + 1'b1;
                        cycle_cnt_d = '0;
                    end
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cycle_cnt_q <= '0;
            run_idx_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            run_idx_q   <= run_idx_d;
            timeout_q   <= timeout_d;
        end
    end
    assign sif.core_rst  = (state_q != RUN) ^ CORE_RST_ACTIVE_LOW;
    assign sif.running   = state_q == RUN;
    assign sif.done      = state_q == DONE;
    assign sif.timeout   = timeout_q;
    assign sif.run_idx   = run_idx_q;
    assign sif.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_arm_run_sequencer.sv
// tb_arm_run_sequencer: directed checks of default and active-low/short-run sequencer configurations
module tb_arm_run_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    always #5 clk = ~clk;
    arm_run_sequencer_if #(.CNT_W(16), .RUN_W(4)) a ();
    arm_run_sequencer_if #(.CNT_W(16), .RUN_W(4)) b ();
    arm_run_sequencer dut_a (.clk(clk), .rst(rst), .sif(a));
    arm_run_sequencer #(
        .RST_CYCLES(4), .RUN_CYCLES(8), .NUM_RUNS(3),
        .CNT_W(16), .RUN_W(4), .CORE_RST_ACTIVE_LOW(1)
    ) dut_b (.clk(clk), .rst(rst), .sif(b));
    // {core_rst, running, done, timeout, run_idx, cycle_cnt}
    logic [23:0] obs_a, obs_b;
    assign obs_a = {a.core_rst, a.running, a.done, a.timeout, a.run_idx, a.cycle_cnt};
    assign obs_b = {b.core_rst, b.running, b.done, b.timeout, b.run_idx, b.cycle_cnt};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
    endtask

    task automatic pass_a(input string name, input int p, input int halt_at, input logic to_in);
        for (int c = 0; c < 2; c++) begin
            vecs++;
            if (obs_a !== {1'b1, 1'b0, 1'b0, to_in, 4'(p), 16'(c)}) begin
                errs++;
                $display("FAIL %s reset p%0d c%0d: got %h want %h", name, p, c, obs_a,
                         {1'b1, 1'b0, 1'b0, to_in, 4'(p), 16'(c)});
            end
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            a.halt_req = (c == halt_at);
            vecs++;
            if (obs_a !== {1'b0, 1'b1, 1'b0, to_in, 4'(p), 16'(c)}) begin
                errs++;
                $display("FAIL %s run p%0d c%0d: got %h want %h", name, p, c, obs_a,
                         {1'b0, 1'b1, 1'b0, to_in, 4'(p), 16'(c)});
            end
            tick();
            if (c == halt_at) break;
        end
        a.halt_req = 1'b0;
    endtask

    task automatic expect_done_a(input string name, input logic to_exp, input int cnt);
        vecs++;
        if (obs_a !== {1'b1, 1'b0, 1'b1, to_exp, 4'd1, 16'(cnt)}) begin
            errs++;
            $display("FAIL %s done: got %h want %h", name, obs_a, {1'b1, 1'b0, 1'b1, to_exp, 4'd1, 16'(cnt)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecs++;
        if (obs_a !== 24'h80_0000) begin
            errs++;
            $display("FAIL reset_a: got %h want %h", obs_a, 24'h80_0000);
        end
        vecs++;
        if (obs_b !== 24'h00_0000) begin
            errs++;
            $display("FAIL reset_b: got %h want %h", obs_b, 24'h00_0000);
        end
        rst = 1'b0;
        tick();
        vecs++;
        if (obs_a !== 24'h80_0000) begin
            errs++;
            $display("FAIL idle_a: got %h want %h", obs_a, 24'h80_0000);
        end
    endtask

    task automatic test_full_run();
        start_a();
        pass_a("full", 0, -1, 1'b0);
        pass_a("full", 1, -1, 1'b1);
        expect_done_a("full", 1'b1, 299);
        tick();
        expect_done_a("full_hold", 1'b1, 299);
    endtask

    task automatic test_halt_early();
        start_a();
        pass_a("halt50", 0, 50, 1'b0);
        pass_a("halt50", 1, -1, 1'b0);
        expect_done_a("halt50", 1'b1, 299);
    endtask

    task automatic test_halt_at_budget();
        start_a();
        pass_a("halt_last", 0, 299, 1'b0);
        pass_a("halt_last", 1, 299, 1'b0);
        expect_done_a("halt_last", 1'b0, 299);
    endtask

    task automatic test_restart();
        a.halt_req = 1'b1;
        tick();
        a.halt_req = 1'b0;
        expect_done_a("restart_pre", 1'b0, 299);
        start_a();
        pass_a("restart", 0, -1, 1'b0);
        pass_a("restart", 1, -1, 1'b1);
        expect_done_a("restart", 1'b1, 299);
    endtask

    task automatic test_abort();
        start_a();
        tick();
        tick();
        for (int c = 0; c < 120; c++) begin
            a.start = (c == 60);
            vecs++;
            if (obs_a !== {4'b0100, 4'd0, 16'(c)}) begin
                errs++;
                $display("FAIL abort_run c%0d: got %h want %h", c, obs_a, {4'b0100, 4'd0, 16'(c)});
            end
            tick();
        end
        a.start = 1'b0;
        vecs++;
        if (obs_a !== {4'b0100, 4'd0, 16'd120}) begin
            errs++;
            $display("FAIL abort_pre: got %h want %h", obs_a, {4'b0100, 4'd0, 16'd120});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++;
        if (obs_a !== 24'h80_0000) begin
            errs++;
            $display("FAIL abort_post: got %h want %h", obs_a, 24'h80_0000);
        end
        tick();
        vecs++;
        if (obs_a !== 24'h80_0000) begin
            errs++;
            $display("FAIL abort_idle: got %h want %h", obs_a, 24'h80_0000);
        end
    endtask

    task automatic test_active_low();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                b.halt_req = 1'b1;
                vecs++;
                if (obs_b !== {3'b000, p > 0, 4'(p), 16'(c)}) begin
                    errs++;
                    $display("FAIL alow_reset p%0d c%0d: got %h want %h", p, c, obs_b, {3'b000, p > 0, 4'(p), 16'(c)});
                end
                tick();
            end
            b.halt_req = 1'b0;
            for (int c = 0; c < 8; c++) begin
                vecs++;
                if (obs_b !== {3'b110, p > 0, 4'(p), 16'(c)}) begin
                    errs++;
                    $display("FAIL alow_run p%0d c%0d: got %h want %h", p, c, obs_b, {3'b110, p > 0, 4'(p), 16'(c)});
                end
                tick();
            end
        end
        vecs++;
        if (obs_b !== {4'b0011, 4'd2, 16'd7}) begin
            errs++;
            $display("FAIL alow_done: got %h want %h", obs_b, {4'b0011, 4'd2, 16'd7});
        end
    endtask

    initial begin
        a.start = 1'b0;
        a.halt_req = 1'b0;
        b.start = 1'b0;
        b.halt_req = 1'b0;
        test_reset();
        test_full_run();
        test_halt_early();
        test_halt_at_budget();
        test_restart();
        test_abort();
        test_active_low();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/arm_run_sequencer.md
Name: arm_run_sequencer

Overview:
- Synthesizable run controller for the ARM core. It drives the core reset, counts execution cycles, and sequences a parametrised number of reset/run passes.
- It replaces fixed "reset, run N cycles, reset again" stimulus with a reusable block, usable in benches and in on-chip self-test wrappers.
- Adds behaviour a fixed sequence lacks: early termination on a core halt request, a per-run cycle budget with timeout flag, a configurable reset polarity to the core, and run indexing.

Parameters:
- RST_CYCLES, 2, cycles core reset is held asserted per pass (>=1, <=2^CNT_W)
- RUN_CYCLES, 300, maximum cycles per run before forced end (>=1, <=2^CNT_W)
- NUM_RUNS, 2, number of reset/run passes per start (>=1, <=2^RUN_W)
- CNT_W, 16, width of cycle counter
- RUN_W, 4, width of run index
- CORE_RST_ACTIVE_LOW, 0, 1 = core_rst driven low when asserted

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high block reset
- start  in  1  begin sequence; sampled in IDLE and DONE only
- halt_req  in  1  core requests end of current run; sampled in RUN only
- core_rst  out  1  reset to core; polarity per CORE_RST_ACTIVE_LOW
- running  out  1  high while in RUN
- done  out  1  high in DONE
- timeout  out  1  sticky: some run hit RUN_CYCLES without halt_req
- run_idx  out  RUN_W  index of current/last run, 0-based
- cycle_cnt  out  CNT_W  cycles elapsed in current RESET/RUN phase

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs registered; no combinational input-to-output paths.
- While rst=1 at an edge:
  - state=IDLE
  - core_rst asserted
  - running=0, done=0, timeout=0, run_idx=0, cycle_cnt=0
- "Asserted" means core_rst=1 if CORE_RST_ACTIVE_LOW=0, else 0.
- States: IDLE, RESET, RUN, DONE.
- IDLE:
  - core_rst asserted; running=0, done=0.
  - start=1 -> RESET; cycle_cnt=0, run_idx=0, timeout=0.
- RESET:
  - core_rst asserted.
  - If cycle_cnt==RST_CYCLES-1 -> RUN, cycle_cnt=0.
  - Else cycle_cnt+1.
  - Net effect: RUN is entered exactly RST_CYCLES edges after the edge that left IDLE/DONE or the previous RUN.
- RUN:
  - core_rst deasserted; running=1.
  - Each edge:
    - If halt_req=1 -> end run.
    - Else if cycle_cnt==RUN_CYCLES-1 -> end run and set timeout=1.
    - Else cycle_cnt+1.
  - halt_req wins over budget expiry in the same cycle (no timeout).
  - Run length without halt is exactly RUN_CYCLES cycles of running=1.
- End of run:
  - If run_idx==NUM_RUNS-1 -> DONE; run_idx holds.
  - Else run_idx+1 -> RESET; cycle_cnt=0.
- DONE:
  - done=1, running=0, core_rst asserted; cycle_cnt holds its final value.
  - start=1 -> RESET with run_idx=0, timeout=0, cycle_cnt=0, done=0.
- start is ignored in RESET and RUN; halt_req is ignored outside RUN.
- rst=1 mid-sequence aborts on that edge to the IDLE reset values; the core is re-held in reset with no glitch-free deassert requirement.
- Counters never wrap. Parameter limits are checked at elaboration (fatal if violated).

Test Plan:
- Reset then start pulse, defaults, halt_req=0 -> core_rst asserted for 2 edges. running high for exactly 300 cycles with cycle_cnt 0..299. Second pass repeats with run_idx=1. Then done=1, timeout=1.
- halt_req=1 at cycle_cnt=50 of run 0 -> run ends that edge and RESET begins. Run 1 runs full budget. Final timeout=1 only due to run 1.
- halt_req=1 exactly at cycle_cnt=RUN_CYCLES-1 on both runs -> done=1 with timeout=0.
- CORE_RST_ACTIVE_LOW=1, RST_CYCLES=4, RUN_CYCLES=8, NUM_RUNS=3 -> core_rst low 4 cycles and high 8 cycles, repeated 3 times. run_idx goes 0,1,2 and done follows the third run.
- rst=1 asserted mid-RUN at cycle_cnt=120 -> next edge: IDLE values, core_rst asserted. start while running (no rst) -> no effect on counters.
- Restart from DONE with start=1 -> timeout and run_idx clear, done drops, and the sequence reruns identically.
